regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, 5, register index width (32 registers).
REQ-003 SHALL have parameter CNT_WIDTH, 8, width of the conflict counter.
REQ-004 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-005 SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- validA  in  1  requester A (ALU writeback) has a write.
- regA  in  ADDR_WIDTH  requester A destination index.
- dataA  in  DATA_WIDTH  requester A write value.
- readyA  out  1  requester A accepted this cycle.
- validB, regB, dataB, readyB  same as A, for requester B (memory load writeback).
- regWrite  out  1  write strobe to the register file.
- writeRegister  out  ADDR_WIDTH  register file write index.
- writeData  out  DATA_WIDTH  register file write value.
- register1, register2  in  ADDR_WIDTH  current read indices of the register file.
- fwd1, fwd2  out  1  in-flight write matches register1 / register2.
- fwdData  out  DATA_WIDTH  bypass value (equals writeData).
- conflictCount  out  CNT_WIDTH  cycles in which both requesters were valid.

Function
REQ-006 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both high.
REQ-007 SHALL drive readyX combinationally high only for the granted requester; with neither valid, readyA=readyB=0.
REQ-008 With one requester valid, SHALL grant it regardless of priority.
REQ-009 With both valid, SHALL grant the requester not granted most recently (lastGrant pointer); after reset A has priority.
REQ-010 SHALL update lastGrant on every grant to the granted requester; hold it otherwise.
REQ-011 SHALL register the accepted request: regWrite, writeRegister, writeData appear exactly 1 cycle after acceptance, regWrite high for exactly 1 cycle per accepted write.
REQ-012 An accepted request with index 0 SHALL be consumed (ready high) but SHALL produce regWrite=0; writeRegister/writeData hold their prior values.
REQ-013 Cycles with no acceptance SHALL give regWrite=0 next cycle; writeRegister/writeData hold.
REQ-014 Both requesters targeting the same index SHALL still be serialised one per cycle in round-robin order; the later commit wins in the register file.
REQ-015 fwd1 SHALL equal regWrite AND (writeRegister == register1) AND (register1 != 0); fwd2 likewise with register2; both combinational.
REQ-016 fwdData SHALL equal writeData at all times.
REQ-017 conflictCount SHALL increment by 1 each cycle validA and validB are both high, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-018 A deasserted valid SHALL drop the request without side effects; requesters must hold reg/data stable while valid and not ready.

Reset
REQ-019 While reset is high: readyA=readyB=0, no request accepted, regardless of valid.
REQ-020 After a reset edge: regWrite=0, writeRegister=0, writeData=0, fwd1=fwd2=0, conflictCount=0, lastGrant=B (so A wins the first conflict).
REQ-021 Reset asserted in the cycle after an acceptance SHALL suppress that pending write (regWrite stays 0).

Structure
REQ-022 DATA_WIDTH, ADDR_WIDTH defaults and the REG_ZERO constant SHALL live in the shared register-file definitions header used by the register file and datapath.
REQ-023 Grant logic plus lastGrant SHALL be a sub-module rr_arbiter2 (2 requests in, 2 one-hot grants out, pointer internal); output register, forwarding and counter stay in the top.

Verification
REQ-024 Only A valid, regA=5, dataA=0x0000_00AA for 1 cycle -> readyA=1 that cycle; next cycle regWrite=1, writeRegister=5, writeData=0xAA; then regWrite=0.
REQ-025 After reset, A and B valid together (regA=3, regB=4) held until accepted -> A granted cycle 0, B cycle 1; regWrite pulses reg 3 then reg 4; conflictCount=1.
REQ-026 Both valid continuously with fresh data each cycle for 6 cycles -> grants alternate A,B,A,B,A,B; conflictCount=6; with CNT_WIDTH=2 it saturates at 3.
REQ-027 A valid with regA=0 -> readyA=1, regWrite stays 0 next cycle, fwd1=0 with register1=0.
REQ-028 B writes reg 7 = 0x1234_5678 with register1=7, register2=8 -> in the commit cycle fwd1=1, fwd2=0, fwdData=0x1234_5678.
REQ-029 A accepted in cycle N, reset high in cycle N+1 -> regWrite=0 in N+1, all outputs at reset values, readyA=0 while reset is high.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions: default widths, the hard-wired zero register,
// and the grant encoding used by the writeback arbiter.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_CNT_WIDTH  = 8;

    // Index 0 reads as zero and never accepts a write.
    localparam logic [RF_ADDR_WIDTH-1:0] REG_ZERO = '0;

    // Which writeback requester was granted most recently.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: one-hot grant, combinational from the requests,
// with an internal last-grant pointer so a contended requester wins the next conflict.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    grant_e last_q;
    grant_e last_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant  = '0;
        last_d = last_q;
        if (!reset) begin
            unique case (req)
                2'b01:   grant[REQ_A] = 1'b1;
                2'b10:   grant[REQ_B] = 1'b1;
                2'b11: begin
                    if (last_q == GRANT_B) grant[REQ_A] = 1'b1;
                    else                   grant[REQ_B] = 1'b1;
                end
                default: grant = '0;
            endcase
        end
        if (grant[REQ_A])      last_d = GRANT_A;
        else if (grant[REQ_B]) last_d = GRANT_B;
    end

    // Pointer starts at B so A wins the first conflict after reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
        if (reset) last_q <= GRANT_B;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port,
// registers the winner, provides read-port forwarding and counts conflict cycles.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = RF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  validA,
    input  logic [ADDR_WIDTH-1:0] regA,
    input  logic [DATA_WIDTH-1:0] dataA,
    output logic                  readyA,
    input  logic                  validB,
    input  logic [ADDR_WIDTH-1:0] regB,
    input  logic [DATA_WIDTH-1:0] dataB,
    output logic                  readyB,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] register1,
    input  logic [ADDR_WIDTH-1:0] register2,
    output logic                  fwd1,
    output logic                  fwd2,
    output logic [DATA_WIDTH-1:0] fwdData,
    output logic [CNT_WIDTH-1:0]  conflictCount
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [1:0]            grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_reg_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({validB, validA}),
        .grant (grant)
    );

    assign readyA = grant[REQ_A];
    assign readyB = grant[REQ_B];
    assign accept = |grant;

    always_comb begin
        sel_reg  = regA;
        sel_data = dataA;
        if (grant[REQ_B]) begin
            sel_reg  = regB;
            sel_data = dataB;
        end
    end

    // Writes to the zero register are consumed but never strobed; index/data hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q <= accept && (sel_reg != ZERO_IDX);
            if (accept && (sel_reg != ZERO_IDX)) begin
                wr_reg_q  <= sel_reg;
                wr_data_q <= sel_data;
            end
            if (validA && validB && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Outputs are forced to their reset values while reset is high, which also
    // squashes a write accepted in the cycle just before reset.
    assign regWrite      = wr_en_q & ~reset;
    assign writeRegister = reset ? '0 : wr_reg_q;
    assign writeData     = reset ? '0 : wr_data_q;
    assign conflictCount = reset ? '0 : cnt_q;
    assign fwdData       = writeData;

    assign fwd1 = regWrite && (writeRegister == register1) && (register1 != ZERO_IDX);
    assign fwd2 = regWrite && (writeRegister == register2) && (register2 != ZERO_IDX);

endmodule
